// File: rtl/alu_result_bcd.sv
// alu_result_bcd
//   Downstream stage of the ALU. Captures the unsigned RESULT magnitude and the
//   NEG flag on a start request, converts the magnitude to packed BCD with a
//   sequential double-dabble (one shift per clock), and then presents the digits
//   and the sign to the display driver with a one-cycle done pulse.
//
// Ports
//   clk     in   1          system clock, rising edge
//   reset   in   1          asynchronous, active-low reset (0 = reset)
//   start   in   1          request conversion of result/neg; sampled in IDLE only
//   result  in   WIDTH      ALU RESULT, unsigned magnitude
//   neg     in   1          ALU NEG flag
//   busy    out  1          conversion in progress (state != IDLE)
//   done    out  1          one-cycle pulse: bcd/sign newly updated
//   bcd     out  4*DIGITS   packed BCD, digit 0 in [3:0]
//   sign    out  1          1 = negative value displayed
//
// DIGITS must satisfy 10**DIGITS > 2**WIDTH-1 so the top digit never overflows.

module alu_result_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      result,
  input  logic                  neg,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_op;
  logic [SW-1:0]   r_scratch;
  logic [CW-1:0]   r_count;
  logic            r_neg;
  logic            r_nonzero;

  logic [SW-1:0]       w_adj;
  logic [SW+WIDTH-1:0] w_next;

  // Add-3 correction on every digit, all from pre-shift values. Each digit is
  // at most 9 before correction, so 4-bit arithmetic never carries.
  always_comb begin
    w_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      else
        w_adj[4*i +: 4] = r_scratch[4*i +: 4];
    end
  end

  // One combined shift of {scratch, op}: op MSB lands in digit 0 LSB.
  assign w_next = {w_adj, r_op} << 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_nonzero <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      sign      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op      <= result;
            r_neg     <= neg;
            r_nonzero <= |result;
            r_scratch <= '0;
            r_count   <= '0;
            busy      <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          // The cycle after the last shift publishes the result, so the done
          // pulse coincides with the DONE state and busy is still high.
          if (r_count == CW'(WIDTH)) begin
            bcd     <= r_scratch;
            sign    <= r_neg & r_nonzero;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            {r_scratch, r_op} <= w_next;
            r_count           <= r_count + CW'(1);
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_bcd.sv
module tb_alu_result_bcd;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int LAT    = WIDTH + 1;   // edges from acceptance to done visible
  localparam int BUSYC  = WIDTH + 2;   // post-edge samples with busy high

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [WIDTH-1:0]    result;
  logic                neg;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                sign;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .result (result),
    .neg    (neg),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd),
    .sign   (sign)
  );

  // Reference: decimal digits of the value by plain division.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_sign(input int unsigned v, input logic n);
    return n && (v != 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, scramble the inputs after acceptance, and wait
  // (bounded) for done, plus one more cycle so the DUT is back in IDLE.
  task automatic convert(input logic [WIDTH-1:0] val, input logic n,
                         output int edges, output int busy_cnt, output int done_cnt);
    result = val;
    neg    = n;
    start  = 1'b1;
    step();
    start    = 1'b0;
    result   = WIDTH'($urandom);
    neg      = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    done_cnt = done ? 1 : 0;
    edges    = 0;
    while (done_cnt == 0 && edges < 100) begin
      step();
      edges++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    step();
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    start  = 1'b0;
    result = '0;
    neg    = 1'b0;
    repeat (3) step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (bcd !== '0) begin n_err++; $display("FAIL reset_bcd: got %h expected 00000", bcd); end
    n_vec++; if (sign !== 1'b0) begin n_err++; $display("FAIL reset_sign: got %b expected 0", sign); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_zero();
    int e, b, d;
    convert(16'h0000, 1'b0, e, b, d);
    n_vec++; if (e != LAT) begin n_err++; $display("FAIL zero_latency: got %0d expected %0d", e, LAT); end
    n_vec++; if (d != 1) begin n_err++; $display("FAIL zero_done_count: got %0d expected 1", d); end
    n_vec++; if (bcd !== ref_bcd(0)) begin n_err++; $display("FAIL zero_bcd: got %h expected %h", bcd, ref_bcd(0)); end
    n_vec++; if (sign !== 1'b0) begin n_err++; $display("FAIL zero_sign: got %b expected 0", sign); end
  endtask

  task automatic test_max();
    int e, b, d;
    convert(16'hFFFF, 1'b0, e, b, d);
    n_vec++; if (bcd !== 20'h65535) begin n_err++; $display("FAIL max_bcd: got %h expected 65535", bcd); end
    n_vec++; if (sign !== 1'b0) begin n_err++; $display("FAIL max_sign: got %b expected 0", sign); end
    n_vec++; if (b != BUSYC) begin n_err++; $display("FAIL max_busy_cycles: got %0d expected %0d", b, BUSYC); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL max_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_sign();
    int e, b, d;
    int dn;
    logic [4*DIGITS-1:0] held;
    convert(16'd1234, 1'b1, e, b, d);
    n_vec++; if (bcd !== 20'h01234) begin n_err++; $display("FAIL sign_bcd: got %h expected 01234", bcd); end
    n_vec++; if (sign !== 1'b1) begin n_err++; $display("FAIL sign_neg: got %b expected 1", sign); end
    // Outputs hold while idle even as the inputs wander.
    held = bcd;
    dn   = 0;
    for (int i = 0; i < 6; i++) begin
      result = WIDTH'($urandom);
      neg    = 1'($urandom);
      step();
      if (done) dn++;
    end
    n_vec++; if (bcd !== 20'h01234) begin n_err++; $display("FAIL hold_bcd: got %h expected %h", bcd, held); end
    n_vec++; if (sign !== 1'b1) begin n_err++; $display("FAIL hold_sign: got %b expected 1", sign); end
    n_vec++; if (dn != 0) begin n_err++; $display("FAIL hold_done: got %0d pulses expected 0", dn); end
    convert(16'd0, 1'b1, e, b, d);
    n_vec++; if (bcd !== 20'h00000) begin n_err++; $display("FAIL negzero_bcd: got %h expected 00000", bcd); end
    n_vec++; if (sign !== 1'b0) begin n_err++; $display("FAIL negzero_sign: got %b expected 0", sign); end
  endtask

  task automatic test_busy_ignore();
    int dn, first;
    int e, b, d;
    result = 16'd9;
    neg    = 1'b0;
    start  = 1'b1;
    step();
    start = 1'b0;
    dn    = 0;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 4 || i == LAT + 1) begin
        result = 16'd999;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) begin
        dn++;
        if (first < 0) first = i;
      end
    end
    start = 1'b0;
    n_vec++; if (first != LAT) begin n_err++; $display("FAIL ignore_latency: got %0d expected %0d", first, LAT); end
    n_vec++; if (dn != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d expected 1", dn); end
    n_vec++; if (bcd !== 20'h00009) begin n_err++; $display("FAIL ignore_bcd: got %h expected 00009", bcd); end
    convert(16'd999, 1'b0, e, b, d);
    n_vec++; if (bcd !== 20'h00999) begin n_err++; $display("FAIL after_ignore_bcd: got %h expected 00999", bcd); end
  endtask

  task automatic test_back_to_back();
    int e, b, d;
    convert(16'd4321, 1'b0, e, b, d);
    convert(16'd8765, 1'b1, e, b, d);
    n_vec++; if (e != LAT) begin n_err++; $display("FAIL b2b_latency: got %0d expected %0d", e, LAT); end
    n_vec++; if (bcd !== 20'h08765) begin n_err++; $display("FAIL b2b_bcd: got %h expected 08765", bcd); end
    n_vec++; if (sign !== 1'b1) begin n_err++; $display("FAIL b2b_sign: got %b expected 1", sign); end
  endtask

  task automatic test_reset_abort();
    int dn;
    int e, b, d;
    result = 16'hFFFF;
    neg    = 1'b1;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    #2 reset = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", done); end
    n_vec++; if (bcd !== '0) begin n_err++; $display("FAIL abort_bcd: got %h expected 00000", bcd); end
    n_vec++; if (sign !== 1'b0) begin n_err++; $display("FAIL abort_sign: got %b expected 0", sign); end
    repeat (2) step();
    reset = 1'b1;
    dn = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done || busy) dn++;
    end
    n_vec++; if (dn != 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dn); end
    convert(16'd42, 1'b0, e, b, d);
    n_vec++; if (e != LAT) begin n_err++; $display("FAIL post_abort_latency: got %0d expected %0d", e, LAT); end
    n_vec++; if (bcd !== 20'h00042) begin n_err++; $display("FAIL post_abort_bcd: got %h expected 00042", bcd); end
  endtask

  task automatic test_random();
    int e, b, d;
    int unsigned v, sel;
    logic n;
    for (int k = 0; k < 1000; k++) begin
      sel = $urandom_range(0, 15);
      if (sel == 0)      v = 0;
      else if (sel == 1) v = 65535;
      else               v = $urandom_range(0, 65535);
      n = 1'($urandom);
      repeat ($urandom_range(0, 2)) step();
      convert(WIDTH'(v), n, e, b, d);
      n_vec++; if (bcd !== ref_bcd(v)) begin n_err++; $display("FAIL rand_bcd[%0d] v=%0d: got %h expected %h", k, v, bcd, ref_bcd(v)); end
      n_vec++; if (sign !== ref_sign(v, n)) begin n_err++; $display("FAIL rand_sign[%0d] v=%0d neg=%b: got %b expected %b", k, v, n, sign, ref_sign(v, n)); end
      n_vec++; if (e != LAT || d != 1) begin n_err++; $display("FAIL rand_timing[%0d]: got latency %0d pulses %0d expected %0d and 1", k, e, d, LAT); end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_sign();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
